// File: rtl/uart_tx_queue_pkg.sv
// Shared constants and types for the UART transmit byte queue.
// Default geometry matches the IO map's UART TX queue; queue_op_e names per-cycle pointer activity.
package uart_tx_queue_pkg;

    localparam int unsigned UART_TXQ_DEPTH = 8;
    localparam int unsigned UART_TXQ_WIDTH = 8;

    // Encoded as {push, pop} so the two handshake bits cast straight into it
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } queue_op_e;

endpackage

// File: rtl/uart_tx_queue_fifo_ptr.sv
// Wrapping FIFO pointer with increment enable and synchronous clear.
// DEPTH is a power of two, so natural binary rollover is the modulo wrap.
module uart_tx_queue_fifo_ptr #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     inc,
    output logic [$clog2(DEPTH)-1:0] ptr
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + PTR_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_queue.sv
// Byte FIFO between the CPU IO decoder and the UART transmitter handshake.
// Status outputs (count/empty/wr_ready/out_valid/out_data) decode directly from registered state.
module uart_tx_queue
    import uart_tx_queue_pkg::*;
#(
    parameter int unsigned DEPTH = UART_TXQ_DEPTH,
    parameter int unsigned WIDTH = UART_TXQ_WIDTH
) (
    input  logic                   clk,
    input  logic                   cpu_rst,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    output logic                   wr_ready,
    input  logic                   flush,
    input  logic                   clr_ovf,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_valid,
    input  logic                   out_ready
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W  = ADDR_W + 1;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] wr_ptr;
    logic [CNT_W-1:0]  cnt;
    logic              ovf;
    logic              full;
    logic              push;
    logic              pop;
    queue_op_e         op;

    assign full  = (cnt == CNT_W'(DEPTH));
    assign empty = (cnt == '0);

    // Flush wins over both handshakes; a pop in a flush cycle is still an accepted handshake at the UART
    assign push = wr_en && !full && !flush;
    assign pop  = !empty && out_ready && !flush;
    assign op   = queue_op_e'({push, pop});

    uart_tx_queue_fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk (clk),
        .rst (cpu_rst),
        .clr (flush),
        .inc (pop),
        .ptr (rd_ptr)
    );

    uart_tx_queue_fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk (clk),
        .rst (cpu_rst),
        .clr (flush),
        .inc (push),
        .ptr (wr_ptr)
    );

    // Storage is deliberately left unreset; out_data masks it while empty
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (cpu_rst || flush) begin
            cnt <= '0;
        end else begin
            case (op)
                OP_PUSH: cnt <= cnt + CNT_W'(1);
                OP_POP:  cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Sticky drop flag: a set beats a same-cycle clear, and flush leaves it alone
    always_ff @(posedge clk) begin
        if (cpu_rst) begin
            ovf <= 1'b0;
        end else if (wr_en && full) begin
            ovf <= 1'b1;
        end else if (clr_ovf) begin
            ovf <= 1'b0;
        end
    end

    assign count     = cnt;
    assign overflow  = ovf;
    assign wr_ready  = !full;
    assign out_valid = !empty;
    assign out_data  = empty ? '0 : mem[rd_ptr];

endmodule

// File: doc/uart_tx_queue.md
Name: uart_tx_queue

Overview:
- Byte FIFO between the CPU memory-mapped IO decoder and the UART transmitter data_in/data_in_valid/data_in_ready handshake.
- A CPU store to the UART TX address pushes one byte. The queue drains bytes to the UART whenever it is ready, so software does not spin on the ready bit for every byte.
- Exposes full, empty, occupancy and a sticky overflow flag for the IO status register.

Parameters:
- DEPTH, 8, number of byte entries; power of two, at least 2.
- WIDTH, 8, data width per entry.
- ADDR_W, $clog2(DEPTH), localparam, pointer width. Count width is ADDR_W+1.

Ports:
- clk  input  1  system clock
- cpu_rst  input  1  synchronous active-high reset
- wr_en  input  1  push request; one-cycle pulse from IO decode on a store to the TX address
- wr_data  input  WIDTH  byte to push (din_io[7:0])
- wr_ready  output  1  high when not full
- flush  input  1  synchronous queue clear (IO control write)
- clr_ovf  input  1  clears the sticky overflow flag
- overflow  output  1  sticky: a push was dropped while full
- count  output  ADDR_W+1  current occupancy, 0..DEPTH
- empty  output  1  count==0
- out_data  output  WIDTH  head byte, to uart data_in
- out_valid  output  1  head valid, to uart data_in_valid
- out_ready  input  1  from uart data_in_ready

Behaviour:
- Reset (cpu_rst high at posedge):
  - rd_ptr=0, wr_ptr=0, count=0, overflow=0.
  - Outputs after reset: out_valid=0, empty=1, wr_ready=1, out_data=0.
  - The storage array is not reset.
- Reset behaviour is identical mid-transfer. A byte offered with out_valid high is abandoned; the UART latched it only if out_ready was high in that same cycle.
- Push condition: wr_en && !full, with full evaluated at the start of the cycle.
  - On push: mem[wr_ptr]<=wr_data and wr_ptr increments, wrapping modulo DEPTH.
  - A simultaneous pop does NOT make room for a push in the same cycle.
- Pop condition: out_valid && out_ready. On pop, rd_ptr increments, wrapping modulo DEPTH.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged, both pointers advance.
- Overflow: wr_en && full sets overflow; the byte is dropped and no state changes.
  - clr_ovf clears overflow.
  - If the set and clear conditions occur in the same cycle, set wins.
  - Overflow is unaffected by flush.
- Flush:
  - pointers and count go to 0 next cycle.
  - Flush overrides any push or pop in the same cycle; a concurrent wr_en byte is discarded without setting overflow.
  - A pop handshake completed in the flush cycle counts as delivered by the UART.
- Outputs are combinational from registered state:
  - out_valid = !empty.
  - out_data = mem[rd_ptr] when !empty, else 0.
  - wr_ready = !full.
  - full = (count==DEPTH).
- Latency: a pushed byte appears on out_valid/out_data the cycle after the push edge. Push-to-UART latency is 1 cycle when the queue was empty.
- Ordering: strict FIFO; no byte is duplicated or lost except through the dropped-push and flush rules.
- Handshake rule: once out_valid is high, out_data and out_valid hold stable until a pop or flush.

Decomposition:
- Shared defines file (defines.v): XLEN, IO_MAP_WIDTH, UART TX/status addresses, default UART_TXQ_DEPTH.
- Optional sub-module fifo_ptr: a wrapping pointer counter with an increment enable and a synchronous clear, instantiated for rd_ptr and wr_ptr. Storage and count stay in uart_tx_queue.

Test Plan:
- Reset, then idle -> count=0, empty=1, out_valid=0, wr_ready=1, overflow=0, out_data=0.
- Push 0x41, 0x42, 0x43 with out_ready=0 -> count=3; out_data=0x41 held. Raise out_ready for 3 cycles -> 0x41, 0x42, 0x43 delivered in order, then empty=1.
- Fill DEPTH=8 with 0x00..0x07, then push 0xFF while full -> count=8, wr_ready=0, overflow=1; drained bytes are 0x00..0x07 only. Pulse clr_ovf -> overflow=0.
- Full queue with wr_en and pop in the same cycle -> count=7, overflow=1, 0xFF not stored. Half-full queue with push and pop in the same cycle -> count unchanged, pointers wrap correctly across 20 such cycles.
- 4 bytes queued, assert flush with wr_en=1 -> next cycle count=0, empty=1, overflow unchanged. A following push of 0x55 appears on out_data 1 cycle later.
- cpu_rst while out_valid=1 and out_ready=0 -> next cycle out_valid=0, count=0. A subsequent push of 0x5A is delivered as the first byte.
